// File: rtl/core_sequencer.sv
// core_sequencer -- multicycle control FSM for the RV32I core.
//
// Walks each instruction through FETCH -> DECODE -> EXEC -> [MEM] -> [WRITE]
// and handshakes with instruction memory, data memory and the UART ports.
// It also produces the IR, register-file and PC write strobes, keeps the
// cycle and retired-instruction counters, and halts on a bus timeout.
//
// Parameters
//   CNT_W    width of cycle_cnt / instret_cnt
//   TIMEOUT  longest allowed handshake wait in cycles (1..2^16-1)
//
// Ports
//   clk, rst                  clock; asynchronous active-low reset
//   run                       permits starting a new fetch
//   mem_read, mem_write,      decoded op flags, sampled in EXEC
//   reg_write, data_in, data_out
//   imem_ack, dmem_ack        memory completion acks
//   rx_valid, tx_ready        UART handshake inputs
//   state                     phase: 0 FETCH, 1 DECODE, 2 EXEC, 3 MEM, 4 WRITE, 5 HALT
//   imem_req, dmem_req        memory requests
//   rx_ready, tx_valid        UART handshake outputs
//   ir_we, rf_we, pc_we       one-cycle write strobes (pc_we = instruction retires)
//   bus_err                   sticky handshake-timeout flag
//   cycle_cnt, instret_cnt    free-running cycle and retired-instruction counters
module core_sequencer #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             reg_write,
    input  logic             data_in,
    input  logic             data_out,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    input  logic             rx_valid,
    input  logic             tx_ready,
    output logic [2:0]       state,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             rx_ready,
    output logic             tx_valid,
    output logic             ir_we,
    output logic             rf_we,
    output logic             pc_we,
    output logic             bus_err,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WRITE  = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    // A wait times out in the cycle that would bring the count to TIMEOUT.
    localparam logic [15:0] WAIT_LIMIT = 16'(TIMEOUT - 1);

    state_t      state_q;
    state_t      state_d;
    logic        op_rd;
    logic        op_wr;
    logic        op_in;
    logic        op_out;
    logic        op_rw;
    logic [15:0] wait_q;
    logic [15:0] wait_d;
    logic        bus_err_q;
    logic        waiting;
    logic        timeout_hit;
    logic        mem_ls;
    logic        mem_done;

    assign state   = state_q;
    assign bus_err = bus_err_q;

    always_comb begin
        state_d     = state_q;
        imem_req    = 1'b0;
        dmem_req    = 1'b0;
        rx_ready    = 1'b0;
        tx_valid    = 1'b0;
        ir_we       = 1'b0;
        rf_we       = 1'b0;
        pc_we       = 1'b0;
        waiting     = 1'b0;
        timeout_hit = 1'b0;
        mem_ls      = op_rd | op_wr;
        // Completion of the single MEM sub-operation, by priority.
        mem_done    = mem_ls ? dmem_ack : (op_in ? rx_valid : tx_ready);

        // Strobes and requests are forced low while reset is held.
        if (rst) begin
            case (state_q)
                S_FETCH: begin
                    imem_req = run;
                    if (run && imem_ack) begin
                        ir_we   = 1'b1;
                        state_d = S_DECODE;
                    end else if (run) begin
                        waiting = 1'b1;
                    end
                end
                S_DECODE: begin
                    state_d = S_EXEC;
                end
                S_EXEC: begin
                    if (mem_read || mem_write || data_in || data_out) begin
                        state_d = S_MEM;
                    end else if (reg_write) begin
                        state_d = S_WRITE;
                    end else begin
                        pc_we   = 1'b1;
                        state_d = S_FETCH;
                    end
                end
                S_MEM: begin
                    dmem_req = mem_ls;
                    rx_ready = !mem_ls && op_in;
                    tx_valid = !mem_ls && !op_in && op_out;
                    if (mem_done) begin
                        if (op_rw) begin
                            state_d = S_WRITE;
                        end else begin
                            pc_we   = 1'b1;
                            state_d = S_FETCH;
                        end
                    end else begin
                        waiting = 1'b1;
                    end
                end
                S_WRITE: begin
                    rf_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = S_FETCH;
                end
                default: begin
                    state_d = S_HALT;
                end
            endcase

            if (waiting && (wait_q == WAIT_LIMIT)) begin
                timeout_hit = 1'b1;
                state_d     = S_HALT;
            end
        end

        // Every state change (entry to FETCH/MEM, completed handshake)
        // restarts the wait count.
        if (state_d != state_q) begin
            wait_d = '0;
        end else if (waiting) begin
            wait_d = wait_q + 16'd1;
        end else begin
            wait_d = wait_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_FETCH;
            op_rd       <= 1'b0;
            op_wr       <= 1'b0;
            op_in       <= 1'b0;
            op_out      <= 1'b0;
            op_rw       <= 1'b0;
            wait_q      <= '0;
            bus_err_q   <= 1'b0;
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (timeout_hit) begin
                bus_err_q <= 1'b1;
            end
            if (state_q == S_EXEC) begin
                op_rd  <= mem_read;
                op_wr  <= mem_write;
                op_in  <= data_in;
                op_out <= data_out;
                op_rw  <= reg_write;
            end
            if (pc_we) begin
                instret_cnt <= instret_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer -- self-checking bench for core_sequencer.
// Each scenario pushes its expected per-cycle output record
// {state, imem_req, dmem_req, rx_ready, tx_valid, ir_we, rf_we, pc_we, bus_err}
// into a queue, then pops and compares one record per clock.
module tb_core_sequencer;

    localparam int CNT_W = 32;
    localparam int TO    = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             run;
    logic             mem_read;
    logic             mem_write;
    logic             reg_write;
    logic             data_in;
    logic             data_out;
    logic             imem_ack;
    logic             dmem_ack;
    logic             rx_valid;
    logic             tx_ready;
    logic [2:0]       state;
    logic             imem_req;
    logic             dmem_req;
    logic             rx_ready;
    logic             tx_valid;
    logic             ir_we;
    logic             rf_we;
    logic             pc_we;
    logic             bus_err;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] instret_cnt;

    int               n_checks = 0;
    int               n_fail   = 0;
    logic [CNT_W-1:0] exp_instret = '0;
    logic [CNT_W-1:0] ref_cyc;
    logic [10:0]      sb[$];
    logic [10:0]      obs_vec;

    always #5 clk = ~clk;

    core_sequencer #(.CNT_W(CNT_W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .run(run),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .data_in(data_in), .data_out(data_out),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .rx_valid(rx_valid), .tx_ready(tx_ready),
        .state(state), .imem_req(imem_req), .dmem_req(dmem_req),
        .rx_ready(rx_ready), .tx_valid(tx_valid),
        .ir_we(ir_we), .rf_we(rf_we), .pc_we(pc_we), .bus_err(bus_err),
        .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    assign obs_vec = {state, imem_req, dmem_req, rx_ready, tx_valid, ir_we, rf_we, pc_we, bus_err};

    // Reference cycle count: edges seen since reset was released.
    always @(posedge clk or negedge rst) begin
        if (!rst) ref_cyc <= '0;
        else      ref_cyc <= ref_cyc + 1;
    end

    function automatic logic [10:0] pk(input logic [2:0] st, input logic ireq, input logic dreq,
                                       input logic rxr, input logic txv, input logic ir,
                                       input logic rf, input logic pc, input logic err);
        return {st, ireq, dreq, rxr, txv, ir, rf, pc, err};
    endfunction

    task automatic clear_inputs();
        run = 0; mem_read = 0; mem_write = 0; reg_write = 0; data_in = 0; data_out = 0;
        imem_ack = 0; dmem_ack = 0; rx_valid = 0; tx_ready = 0;
    endtask

    task automatic test_reset();
        logic [10:0] exp;
        rst = 0; run = 1; mem_read = 1; mem_write = 1; reg_write = 1; data_in = 1; data_out = 1;
        imem_ack = 1; dmem_ack = 1; rx_valid = 1; tx_ready = 1;
        sb.push_back(pk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        #2;
        exp = sb.pop_front();
        n_checks++; if (obs_vec !== exp) begin n_fail++; $display("FAIL reset_outputs: got %h expected %h", obs_vec, exp); end
        n_checks++; if (cycle_cnt !== 0) begin n_fail++; $display("FAIL reset_cycle_cnt: got %0d expected 0", cycle_cnt); end
        n_checks++; if (instret_cnt !== 0) begin n_fail++; $display("FAIL reset_instret: got %0d expected 0", instret_cnt); end
        clear_inputs();
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        n_checks++; if (cycle_cnt !== 1) begin n_fail++; $display("FAIL cycle_cnt_first_edge: got %0d expected 1", cycle_cnt); end
        n_checks++; if (state !== 3'd0) begin n_fail++; $display("FAIL reset_idle_state: got %0d expected 0", state); end
        exp_instret = '0;
    endtask

    task automatic end_checks(input string name);
        n_checks++; if (state !== 3'd0) begin n_fail++; $display("FAIL %s_end_state: got %0d expected 0", name, state); end
        n_checks++; if (instret_cnt !== exp_instret) begin n_fail++; $display("FAIL %s_instret: got %0d expected %0d", name, instret_cnt, exp_instret); end
        n_checks++; if (cycle_cnt !== ref_cyc) begin n_fail++; $display("FAIL %s_cycle_cnt: got %0d expected %0d", name, cycle_cnt, ref_cyc); end
    endtask

    task automatic test_addi();
        logic [10:0] exp;
        clear_inputs(); run = 1; imem_ack = 1; reg_write = 1;
        sb.push_back(pk(0, 1, 0, 0, 0, 1, 0, 0, 0));
        sb.push_back(pk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        sb.push_back(pk(2, 0, 0, 0, 0, 0, 0, 0, 0));
        sb.push_back(pk(4, 0, 0, 0, 0, 0, 1, 1, 0));
        for (int i = 0; i < 4; i++) begin
            #2;
            exp = sb.pop_front();
            n_checks++; if (obs_vec !== exp) begin n_fail++; $display("FAIL addi cycle %0d: got %h expected %h", i, obs_vec, exp); end
            if (exp[1]) exp_instret++;
            @(posedge clk); #1;
        end
        end_checks("addi");
    endtask

    // lw with dmem_ack three cycles late; data_out also set to check priority.
    task automatic test_lw_wait();
        logic [10:0] exp;
        clear_inputs(); run = 1; imem_ack = 1; mem_read = 1; reg_write = 1; data_out = 1;
        sb.push_back(pk(0, 1, 0, 0, 0, 1, 0, 0, 0));
        sb.push_back(pk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        sb.push_back(pk(2, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 4; k++) sb.push_back(pk(3, 0, 1, 0, 0, 0, 0, 0, 0));
        sb.push_back(pk(4, 0, 0, 0, 0, 0, 1, 1, 0));
        for (int i = 0; i < 8; i++) begin
            dmem_ack = (i == 6);
            #2;
            exp = sb.pop_front();
            n_checks++; if (obs_vec !== exp) begin n_fail++; $display("FAIL lw_wait cycle %0d: got %h expected %h", i, obs_vec, exp); end
            if (exp[1]) exp_instret++;
            @(posedge clk); #1;
        end
        end_checks("lw_wait");
    endtask

    task automatic test_sw();
        logic [10:0] exp;
        clear_inputs(); run = 1; imem_ack = 1; mem_write = 1; dmem_ack = 1;
        sb.push_back(pk(0, 1, 0, 0, 0, 1, 0, 0, 0));
        sb.push_back(pk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        sb.push_back(pk(2, 0, 0, 0, 0, 0, 0, 0, 0));
        sb.push_back(pk(3, 0, 1, 0, 0, 0, 0, 1, 0));
        for (int i = 0; i < 4; i++) begin
            #2;
            exp = sb.pop_front();
            n_checks++; if (obs_vec !== exp) begin n_fail++; $display("FAIL sw cycle %0d: got %h expected %h", i, obs_vec, exp); end
            if (exp[1]) exp_instret++;
            @(posedge clk); #1;
        end
        end_checks("sw");
    endtask

    task automatic test_out();
        logic [10:0] exp;
        clear_inputs(); run = 1; imem_ack = 1; data_out = 1;
        sb.push_back(pk(0, 1, 0, 0, 0, 1, 0, 0, 0));
        sb.push_back(pk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        sb.push_back(pk(2, 0, 0, 0, 0, 0, 0, 0, 0));
        sb.push_back(pk(3, 0, 0, 0, 1, 0, 0, 0, 0));
        sb.push_back(pk(3, 0, 0, 0, 1, 0, 0, 0, 0));
        sb.push_back(pk(3, 0, 0, 0, 1, 0, 0, 1, 0));
        for (int i = 0; i < 6; i++) begin
            tx_ready = (i == 5);
            #2;
            exp = sb.pop_front();
            n_checks++; if (obs_vec !== exp) begin n_fail++; $display("FAIL out cycle %0d: got %h expected %h", i, obs_vec, exp); end
            if (exp[1]) exp_instret++;
            @(posedge clk); #1;
        end
        end_checks("out");
    endtask

    // Input-port instruction with register write; data_out also set (in wins).
    task automatic test_in();
        logic [10:0] exp;
        clear_inputs(); run = 1; imem_ack = 1; data_in = 1; data_out = 1; reg_write = 1; rx_valid = 1; tx_ready = 1;
        sb.push_back(pk(0, 1, 0, 0, 0, 1, 0, 0, 0));
        sb.push_back(pk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        sb.push_back(pk(2, 0, 0, 0, 0, 0, 0, 0, 0));
        sb.push_back(pk(3, 0, 0, 1, 0, 0, 0, 0, 0));
        sb.push_back(pk(4, 0, 0, 0, 0, 0, 1, 1, 0));
        for (int i = 0; i < 5; i++) begin
            #2;
            exp = sb.pop_front();
            n_checks++; if (obs_vec !== exp) begin n_fail++; $display("FAIL in cycle %0d: got %h expected %h", i, obs_vec, exp); end
            if (exp[1]) exp_instret++;
            @(posedge clk); #1;
        end
        end_checks("in");
    endtask

    // Branch with run dropped in EXEC; fetch stalls (ack ignored) until run returns.
    task automatic test_beq_run();
        logic [10:0] exp;
        clear_inputs(); run = 1; imem_ack = 1;
        sb.push_back(pk(0, 1, 0, 0, 0, 1, 0, 0, 0));
        sb.push_back(pk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        sb.push_back(pk(2, 0, 0, 0, 0, 0, 0, 1, 0));
        sb.push_back(pk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        sb.push_back(pk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        sb.push_back(pk(0, 1, 0, 0, 0, 1, 0, 0, 0));
        sb.push_back(pk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        sb.push_back(pk(2, 0, 0, 0, 0, 0, 0, 1, 0));
        for (int i = 0; i < 8; i++) begin
            if (i == 2) run = 0;
            if (i == 5) run = 1;
            #2;
            exp = sb.pop_front();
            n_checks++; if (obs_vec !== exp) begin n_fail++; $display("FAIL beq_run cycle %0d: got %h expected %h", i, obs_vec, exp); end
            if (exp[1]) exp_instret++;
            @(posedge clk); #1;
        end
        end_checks("beq_run");
    endtask

    task automatic test_fetch_timeout();
        logic [10:0] exp;
        clear_inputs(); run = 1;
        for (int k = 0; k < TO; k++) sb.push_back(pk(0, 1, 0, 0, 0, 0, 0, 0, 0));
        sb.push_back(pk(5, 0, 0, 0, 0, 0, 0, 0, 1));
        sb.push_back(pk(5, 0, 0, 0, 0, 0, 0, 0, 1));
        for (int i = 0; i < TO + 2; i++) begin
            if (i == TO) begin imem_ack = 1; dmem_ack = 1; rx_valid = 1; tx_ready = 1; reg_write = 1; end
            #2;
            exp = sb.pop_front();
            n_checks++; if (obs_vec !== exp) begin n_fail++; $display("FAIL fetch_timeout cycle %0d: got %h expected %h", i, obs_vec, exp); end
            @(posedge clk); #1;
        end
        n_checks++; if (instret_cnt !== exp_instret) begin n_fail++; $display("FAIL halt_instret: got %0d expected %0d", instret_cnt, exp_instret); end
        n_checks++; if (cycle_cnt !== ref_cyc) begin n_fail++; $display("FAIL halt_cycle_cnt: got %0d expected %0d", cycle_cnt, ref_cyc); end
        rst = 0;
        sb.push_back(pk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        #2;
        exp = sb.pop_front();
        n_checks++; if (obs_vec !== exp) begin n_fail++; $display("FAIL halt_reset_clear: got %h expected %h", obs_vec, exp); end
        clear_inputs();
        @(posedge clk); #1;
        rst = 1;
        exp_instret = '0;
    endtask

    // Output port whose tx_ready never arrives: MEM times out after TO cycles.
    task automatic test_mem_timeout();
        logic [10:0] exp;
        clear_inputs(); run = 1; imem_ack = 1; data_out = 1;
        sb.push_back(pk(0, 1, 0, 0, 0, 1, 0, 0, 0));
        sb.push_back(pk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        sb.push_back(pk(2, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < TO; k++) sb.push_back(pk(3, 0, 0, 0, 1, 0, 0, 0, 0));
        sb.push_back(pk(5, 0, 0, 0, 0, 0, 0, 0, 1));
        for (int i = 0; i < TO + 4; i++) begin
            tx_ready = (i == TO + 3);
            #2;
            exp = sb.pop_front();
            n_checks++; if (obs_vec !== exp) begin n_fail++; $display("FAIL mem_timeout cycle %0d: got %h expected %h", i, obs_vec, exp); end
            @(posedge clk); #1;
        end
        n_checks++; if (instret_cnt !== exp_instret) begin n_fail++; $display("FAIL mem_timeout_instret: got %0d expected %0d", instret_cnt, exp_instret); end
        rst = 0;
        #2;
        n_checks++; if (bus_err !== 1'b0 || state !== 3'd0) begin n_fail++; $display("FAIL mem_timeout_reset: got err=%b state=%0d expected err=0 state=0", bus_err, state); end
        clear_inputs();
        @(posedge clk); #1;
        rst = 1;
        exp_instret = '0;
    endtask

    initial begin
        clear_inputs();
        rst = 0;
        test_reset();
        test_addi();
        test_lw_wait();
        test_sw();
        test_out();
        test_in();
        test_beq_run();
        test_fetch_timeout();
        test_mem_timeout();
        test_addi();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
